// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE bit positions and X/Z mux select codes for the DSP48A1 slice.
`timescale 1ns/1ps
package dsp48a1_pkg;
   localparam int A_W = 18;
   localparam int M_W = 36;
   localparam int P_W = 48;

   localparam int OP_USE_PREADD  = 4;
   localparam int OP_CIN         = 5;
   localparam int OP_PREADD_SUB  = 6;
   localparam int OP_POSTADD_SUB = 7;

   typedef enum logic [1:0] {X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3} x_sel_e;
   typedef enum logic [1:0] {Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3} z_sel_e;

   // Pre-adder stage: D +/- B0 with 18-bit wrap, or plain B0 pass-through.
   function automatic logic [A_W-1:0] preadd(input logic [7:0] op,
                                             input logic [A_W-1:0] d,
                                             input logic [A_W-1:0] b);
      if (!op[OP_USE_PREADD])
         return b;
      return op[OP_PREADD_SUB] ? (d - b) : (d + b);
   endfunction
endpackage

// File: rtl/dsp_reg_mux.sv
// Optionally bypassed pipeline register with clock enable and async active-high reset.
`timescale 1ns/1ps
module dsp_reg_mux #(
   parameter int WIDTH  = 18,
   parameter int REG_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   generate
      if (REG_EN != 0) begin : g_reg
         logic [WIDTH-1:0] q_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               q_reg <= '0;
            else if (ce)
               q_reg <= d;
         end
         assign q = q_reg;
      end else begin : g_bypass
         // Bypassed stage is pure wiring; clock, enable and reset are ignored.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, ce};
         assign q = d;
      end
   endgenerate
endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1 slice: pre-adder, 18x18 multiplier, 48-bit post-adder, per-stage optional registers.
// Build option: DSP_BCIN_CASCADE_EN enables the B_INPUT selection between B and BCIN.
`timescale 1ns/1ps
module dsp48a1_slice
   import dsp48a1_pkg::*;
#(
   parameter int    A0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B0REG       = 0,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT"
) (
   input  logic           clk,
   input  logic           RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE,
   input  logic [A_W-1:0] A, B, D, BCIN,
   input  logic [P_W-1:0] C, PCIN,
   input  logic [7:0]     OPMODE,
   input  logic           CARRYIN,
   input  logic           CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE,
   output logic [A_W-1:0] BCOUT,
   output logic [P_W-1:0] PCOUT,
   output logic [P_W-1:0] P,
   output logic [M_W-1:0] M,
   output logic           CARRYOUT,
   output logic           CARRYOUTF
);
   logic [A_W-1:0] b0_in, a0_reg, a1_reg, b0_reg, b1_reg, d_reg, b1_next;
   logic [P_W-1:0] c_reg, x_mux, z_mux;
   logic [M_W-1:0] m_reg, m_next;
   logic [7:0]     opmode_reg;
   logic           cin_next, cin_reg;
   logic [P_W:0]   post_sum;

`ifdef DSP_BCIN_CASCADE_EN
   assign b0_in = (B_INPUT == "CASCADE") ? BCIN : B;
`else
   logic [A_W-1:0] unused_bcin;
   localparam bit unused_b_input = (B_INPUT == "CASCADE");
   assign unused_bcin = BCIN;
   assign b0_in       = B;
`endif

   dsp_reg_mux #(.WIDTH(A_W), .REG_EN(A0REG))     u_a0  (.clk(clk), .rst(RSTA), .ce(CEA), .d(A),      .q(a0_reg));
   dsp_reg_mux #(.WIDTH(A_W), .REG_EN(A1REG))     u_a1  (.clk(clk), .rst(RSTA), .ce(CEA), .d(a0_reg), .q(a1_reg));
   dsp_reg_mux #(.WIDTH(A_W), .REG_EN(B0REG))     u_b0  (.clk(clk), .rst(RSTB), .ce(CEB), .d(b0_in),  .q(b0_reg));
   dsp_reg_mux #(.WIDTH(A_W), .REG_EN(DREG))      u_d   (.clk(clk), .rst(RSTD), .ce(CED), .d(D),      .q(d_reg));
   dsp_reg_mux #(.WIDTH(P_W), .REG_EN(CREG))      u_c   (.clk(clk), .rst(RSTC), .ce(CEC), .d(C),      .q(c_reg));
   dsp_reg_mux #(.WIDTH(8),   .REG_EN(OPMODEREG)) u_op  (.clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE),
                                                         .d(OPMODE), .q(opmode_reg));

   assign b1_next = preadd(opmode_reg, d_reg, b0_reg);
   dsp_reg_mux #(.WIDTH(A_W), .REG_EN(B1REG))     u_b1  (.clk(clk), .rst(RSTB), .ce(CEB), .d(b1_next), .q(b1_reg));
   assign BCOUT = b1_reg;

   assign m_next = {{(M_W-A_W){1'b0}}, b1_reg} * {{(M_W-A_W){1'b0}}, a1_reg};
   dsp_reg_mux #(.WIDTH(M_W), .REG_EN(MREG))      u_m   (.clk(clk), .rst(RSTM), .ce(CEM), .d(m_next), .q(m_reg));
   assign M = m_reg;

   // Carry-in is taken from the registered OPMODE so it lines up with the X/Z selects.
   assign cin_next = (CARRYINSEL == "CARRYIN") ? CARRYIN : opmode_reg[OP_CIN];
   dsp_reg_mux #(.WIDTH(1), .REG_EN(CARRYINREG))  u_cin (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN),
                                                         .d(cin_next), .q(cin_reg));

   always_comb begin
      x_mux = '0;
      case (x_sel_e'(opmode_reg[1:0]))
         X_ZERO:  x_mux = '0;
         X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_reg};
         X_P:     x_mux = P;
         X_DAB:   x_mux = {d_reg[11:0], a1_reg, b1_reg};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      case (z_sel_e'(opmode_reg[3:2]))
         Z_ZERO:  z_mux = '0;
         Z_PCIN:  z_mux = PCIN;
         Z_P:     z_mux = P;
         Z_C:     z_mux = c_reg;
         default: z_mux = '0;
      endcase
   end

   // Bit 48 is the carry on add and the borrow flag on subtract.
   always_comb begin
      if (opmode_reg[OP_POSTADD_SUB])
         post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_reg});
      else
         post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_reg};
   end

   dsp_reg_mux #(.WIDTH(P_W), .REG_EN(PREG))        u_p  (.clk(clk), .rst(RSTP), .ce(CEP),
                                                         .d(post_sum[P_W-1:0]), .q(P));
   dsp_reg_mux #(.WIDTH(1),   .REG_EN(CARRYOUTREG)) u_co (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN),
                                                         .d(post_sum[P_W]), .q(CARRYOUT));
   assign PCOUT     = P;
   assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// Self-checking bench for dsp48a1_slice: directed paths plus randomized steady-state/accumulate runs.
`timescale 1ns/1ps
module tb_dsp48a1_slice;
   localparam longint unsigned MASK18 = 64'h3FFFF;
   localparam longint unsigned MASK48 = 64'hFFFF_FFFF_FFFF;
   localparam longint unsigned MASK49 = 64'h1_FFFF_FFFF_FFFF;

   logic        clk;
   logic        RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
   logic [17:0] A, B, D, BCIN;
   logic [47:0] C, PCIN;
   logic [7:0]  OPMODE;
   logic        CARRYIN;
   logic        CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE;
   logic [17:0] BCOUT;
   logic [47:0] PCOUT, P;
   logic [35:0] M;
   logic        CARRYOUT, CARRYOUTF;

   int checks   = 0;
   int failures = 0;

   dsp48a1_slice dut (
      .clk(clk),
      .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC), .RSTD(RSTD),
      .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
      .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .OPMODE(OPMODE), .CARRYIN(CARRYIN),
      .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
      .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
      .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
   );

   initial clk = 1'b0;
   always #1 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rst(input logic v);
      {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE} = {8{v}};
   endtask

   task automatic set_ce(input logic v);
      {CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE} = {8{v}};
   endtask

   // Reference: what each stage settles to when inputs are held constant.
   function automatic longint unsigned ref_b1(input logic [7:0] op, input longint unsigned d,
                                              input longint unsigned b);
      if (!op[4]) return b;
      return op[6] ? ((d - b) & MASK18) : ((d + b) & MASK18);
   endfunction

   function automatic longint unsigned ref_x(input logic [7:0] op, input longint unsigned m,
                                             input longint unsigned p, input longint unsigned d,
                                             input longint unsigned a, input longint unsigned b1);
      case (op[1:0])
         2'd0:    return 0;
         2'd1:    return m;
         2'd2:    return p;
         default: return ((d & 64'hFFF) << 36) | (a << 18) | b1;
      endcase
   endfunction

   function automatic longint unsigned ref_z(input logic [7:0] op, input longint unsigned pcin,
                                             input longint unsigned p, input longint unsigned c);
      case (op[3:2])
         2'd0:    return 0;
         2'd1:    return pcin;
         2'd2:    return p;
         default: return c;
      endcase
   endfunction

   // 49-bit result: low 48 bits are P, bit 48 is carry/borrow.
   function automatic longint unsigned ref_post(input logic [7:0] op, input longint unsigned x,
                                                input longint unsigned z, input longint unsigned cin);
      if (op[7]) return (z - (x + cin)) & MASK49;
      return (z + x + cin) & MASK49;
   endfunction

   longint unsigned ra, rb, rd, rc, rpcin, rb1, rm, rp, rs, rco;
   logic [7:0] rop;
   int n;

   initial begin
      // Reset with enables off and random inputs: every output must read zero.
      set_rst(1'b1);
      set_ce(1'b0);
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom); BCIN = 18'($urandom);
      C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
      OPMODE = 8'($urandom); CARRYIN = 1'($urandom);
      tick(1);
      check("rst_m", 48'(M), 48'h0);
      check("rst_p", P, 48'h0);
      check("rst_pcout", PCOUT, 48'h0);
      check("rst_bcout", 48'(BCOUT), 48'h0);
      check("rst_co", 48'(CARRYOUT), 48'h0);
      check("rst_cof", 48'(CARRYOUTF), 48'h0);

      // Path 1: C - (D-B)*A, checked at exactly the 4-clock latency.
      set_rst(1'b0);
      set_ce(1'b1);
      OPMODE = 8'hDD; A = 18'd20; B = 18'd10; C = 48'd350; D = 18'd25;
      PCIN = 48'd0; CARRYIN = 1'b0; BCIN = 18'd0;
      tick(4);
      check("p1_bcout", 48'(BCOUT), 48'h0F);
      check("p1_m", 48'(M), 48'h12C);
      check("p1_p", P, 48'h32);
      check("p1_pcout", PCOUT, 48'h32);
      check("p1_co", 48'(CARRYOUT), 48'h0);
      $display("path1 op=dd P=%h M=%h BCOUT=%h", P, M, BCOUT);

      // Path 2: pre-add D+B, post-adder selects zero.
      OPMODE = 8'h10;
      tick(3);
      check("p2_bcout", 48'(BCOUT), 48'h23);
      check("p2_m", 48'(M), 48'h2BC);
      check("p2_p", P, 48'h0);
      check("p2_co", 48'(CARRYOUT), 48'h0);
      $display("path2 op=10 P=%h M=%h BCOUT=%h", P, M, BCOUT);

      // Path 3: P + P starting from zero must stay zero.
      OPMODE = 8'h0A;
      tick(5);
      check("p3_bcout", 48'(BCOUT), 48'h0A);
      check("p3_m", 48'(M), 48'hC8);
      check("p3_p", P, 48'h0);
      $display("path3 op=0a P=%h M=%h BCOUT=%h", P, M, BCOUT);

      // Path 4: PCIN - ({D,A,B} + 1) goes negative and sets the borrow.
      OPMODE = 8'hA7; A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
      tick(5);
      check("p4_bcout", 48'(BCOUT), 48'h6);
      check("p4_m", 48'(M), 48'h1E);
      check("p4_p", P, 48'hFE6FFFEC0BB1);
      check("p4_pcout", PCOUT, 48'hFE6FFFEC0BB1);
      check("p4_co", 48'(CARRYOUT), 48'h1);
      check("p4_cof", 48'(CARRYOUTF), 48'h1);
      $display("path4 op=a7 P=%h CO=%0b", P, CARRYOUT);

      // Async RSTP between edges clears P before the next rising edge.
      #0.5 RSTP = 1'b1;
      #0.2;
      check("arst_p", P, 48'h0);
      check("arst_pcout", PCOUT, 48'h0);
      $display("async_rstp P=%h PCOUT=%h", P, PCOUT);
      @(negedge clk);
      RSTP = 1'b0;

      // Randomized: settle with P frozen, then let P run for n cycles.
      for (int t = 0; t < 20; t++) begin
         set_rst(1'b1);
         tick(1);
         set_rst(1'b0);
         ra = 64'($urandom) & MASK18; rb = 64'($urandom) & MASK18; rd = 64'($urandom) & MASK18;
         rc = {32'($urandom), 32'($urandom)} & MASK48;
         rpcin = {32'($urandom), 32'($urandom)} & MASK48;
         rop = 8'($urandom);
         A = 18'(ra); B = 18'(rb); D = 18'(rd); C = 48'(rc); PCIN = 48'(rpcin); OPMODE = rop;
         BCIN = 18'($urandom); CARRYIN = 1'($urandom);
         set_ce(1'b1);
         CEP = 1'b0;
         tick(5);
         rb1 = ref_b1(rop, rd, rb);
         rm  = rb1 * ra;
         check("rnd_bcout", 48'(BCOUT), 48'(rb1));
         check("rnd_m", 48'(M), 48'(rm));
         check("rnd_p_hold", P, 48'h0);
         n = int'($urandom_range(1, 4));
         rp = 0; rco = 0;
         for (int k = 0; k < n; k++) begin
            rs  = ref_post(rop, ref_x(rop, rm, rp, rd, ra, rb1), ref_z(rop, rpcin, rp, rc),
                           64'(rop[5]));
            rco = rs >> 48;
            rp  = rs & MASK48;
         end
         CEP = 1'b1;
         tick(n);
         check("rnd_p", P, 48'(rp));
         check("rnd_pcout", PCOUT, 48'(rp));
         check("rnd_co", 48'(CARRYOUT), 48'(rco));
         check("rnd_cof", 48'(CARRYOUTF), 48'(rco));
         CEP = 1'b0;
         $display("txn %0d op=%02h n=%0d P=%h exp=%h CO=%0b", t, rop, n, P, rp, CARRYOUT);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
